// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// Combinational definitions only; no latency, no backpressure.
// Imported by the padder top and its block buffer.
package sha256_pkg;

    localparam int BLK_W     = 512;
    localparam int LEN_W     = 64;
    localparam int BLK_BYTES = BLK_W / 8;
    localparam int BIDX_W    = 6;
    // One extra bit so the index can express "all 64 bytes used".
    localparam int IDX_W     = BIDX_W + 1;
    localparam int CNT_W     = LEN_W - 3;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_PAD,
        ST_SEND,
        ST_EXTRA
    } state_t;

    typedef enum logic [1:0] {
        AFT_FILL,
        AFT_EXTRA,
        AFT_DONE
    } after_t;

    typedef struct packed {
        logic              en;
        logic [BIDX_W-1:0] idx;
        logic [7:0]        dat;
    } byte_wr_t;

    function automatic logic [LEN_W-1:0] bit_len(input logic [CNT_W-1:0] nbytes);
        return {nbytes, 3'b000};
    endfunction

endpackage

// File: rtl/sha256_block_buf.sv
// 64-byte block register: one byte write per cycle, length-field write, sync clear.
// Writes are visible on data the cycle after they are requested.
// No handshake; the owner must only write when the block is not being presented.
module sha256_block_buf
    import sha256_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr,
    input  byte_wr_t         byte_wr,
    input  logic             len_wr,
    input  logic [LEN_W-1:0] len_val,
    output logic [BLK_W-1:0] data
);

    logic [BLK_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (clr) begin
            data_q <= '0;
        end else begin
            for (int i = 0; i < BLK_BYTES; i++) begin
                if (byte_wr.en && byte_wr.idx == BIDX_W'(i)) begin
                    data_q[BLK_W-1-8*i -: 8] <= byte_wr.dat;
                end
            end
            // Length occupies bytes 56..63 and is never written together with those bytes.
            if (len_wr) begin
                data_q[LEN_W-1:0] <= len_val;
            end
        end
    end

    assign data = data_q;

endmodule

// File: rtl/sha256_padder.sv
// Byte-stream to padded 512-bit block front end for the sha256 core.
// Last byte to blk_valid: 2 cycles; full mid-message block: 1 cycle; extra block: 2 cycles after prior transfer.
// in_ready drops while a block is pending; blk_data/blk_new hold until blk_ready.
module sha256_padder
    import sha256_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             blk_valid,
    output logic [BLK_W-1:0] blk_data,
    output logic             blk_new,
    input  logic             blk_ready
);

    state_t           state, state_n;
    after_t           after, after_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] len, len_n;
    logic             first, first_n;
    logic             mark, mark_n;

    byte_wr_t         byte_wr;
    logic             clr;
    logic             len_wr;
    logic             take;
    logic             xfer;

    assign take = in_valid && in_ready;
    assign xfer = blk_valid && blk_ready;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_FILL;
            after     <= AFT_FILL;
            idx       <= '0;
            len       <= '0;
            first     <= 1'b1;
            mark      <= 1'b0;
            in_ready  <= 1'b0;
            blk_valid <= 1'b0;
            blk_new   <= 1'b0;
        end else begin
            state     <= state_n;
            after     <= after_n;
            idx       <= idx_n;
            len       <= len_n;
            first     <= first_n;
            mark      <= mark_n;
            in_ready  <= (state_n == ST_FILL);
            blk_valid <= (state_n == ST_SEND);
            blk_new   <= first_n;
        end
    end

    always_comb begin
        state_n = state;
        after_n = after;
        idx_n   = idx;
        len_n   = len;
        first_n = first;
        mark_n  = mark;
        byte_wr = '0;
        clr     = 1'b0;
        len_wr  = 1'b0;

        case (state)
            ST_FILL: begin
                if (take) begin
                    byte_wr = '{en: 1'b1, idx: idx[BIDX_W-1:0], dat: in_data};
                    idx_n   = idx + IDX_W'(1);
                    len_n   = len + CNT_W'(1);
                    if (in_last) begin
                        state_n = ST_PAD;
                    end else if (idx == IDX_W'(63)) begin
                        state_n = ST_SEND;
                        after_n = AFT_FILL;
                    end
                end
            end

            // idx now holds the number of bytes used in this block (1..64).
            ST_PAD: begin
                state_n = ST_SEND;
                if (idx <= IDX_W'(55)) begin
                    byte_wr = '{en: 1'b1, idx: idx[BIDX_W-1:0], dat: PAD_BYTE};
                    len_wr  = 1'b1;
                    after_n = AFT_DONE;
                end else if (idx <= IDX_W'(63)) begin
                    byte_wr = '{en: 1'b1, idx: idx[BIDX_W-1:0], dat: PAD_BYTE};
                    after_n = AFT_EXTRA;
                    mark_n  = 1'b1;
                end else begin
                    after_n = AFT_EXTRA;
                    mark_n  = 1'b0;
                end
            end

            ST_SEND: begin
                if (xfer) begin
                    clr     = 1'b1;
                    first_n = 1'b0;
                    case (after)
                        AFT_FILL: begin
                            state_n = ST_FILL;
                            idx_n   = '0;
                        end
                        AFT_EXTRA: begin
                            state_n = ST_EXTRA;
                        end
                        default: begin
                            state_n = ST_FILL;
                            idx_n   = '0;
                            len_n   = '0;
                            first_n = 1'b1;
                        end
                    endcase
                end
            end

            // Buffer was cleared on the previous transfer; only byte 0 and the length remain.
            ST_EXTRA: begin
                byte_wr = '{en: 1'b1, idx: '0, dat: (mark ? 8'h00 : PAD_BYTE)};
                len_wr  = 1'b1;
                after_n = AFT_DONE;
                state_n = ST_SEND;
            end

            default: begin
                state_n = ST_FILL;
            end
        endcase
    end

    sha256_block_buf u_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr     (clr),
        .byte_wr (byte_wr),
        .len_wr  (len_wr),
        .len_val (bit_len(len)),
        .data    (blk_data)
    );

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: directed vectors plus random messages
// compared against a list-based padding model.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_new;
    logic         blk_ready = 1'b0;

    sha256_padder dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_new   (blk_new),
        .blk_ready (blk_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    byte unsigned msg_q[$];
    logic [511:0] exp_q[$];
    logic [511:0] got_q[$];
    logic         got_new_q[$];
    int           seen_cyc[$];
    int           rdy_cyc[$];
    int           last_pres;
    int           pres63;

    typedef struct {
        int           len;
        byte unsigned fill;
        int           stall;
        int           exp_blk;
        logic [63:0]  exp_len;
        int           pad_blk;
        int           pad_byte;
    } vec_t;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Padding computed as a flat byte list: msg, 0x80, zeros to 56 mod 64, 8-byte length.
    task automatic model();
        byte unsigned p[$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        p = msg_q;
        bitlen = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        exp_q.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b + j];
            exp_q.push_back(blk);
        end
    endtask

    task automatic drive(input int gap, input bit use_last);
        int   i = 0;
        int   guard = 0;
        logic acc;
        while (i < msg_q.size() && guard < 5000) begin
            if (gap > 0 && $urandom_range(0, 99) < gap) begin
                in_valid = 1'b0;
                acc = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = msg_q[i];
                in_last  = use_last && (i == msg_q.size() - 1);
                acc      = in_ready;
            end
            if (acc) begin
                if (i == msg_q.size() - 1) last_pres = cyc;
                if (i == 63) pres63 = cyc;
                i++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bytes_sent", i, msg_q.size());
    endtask

    task automatic collect(input int nblk, input int stall);
        int           got = 0;
        int           waited = 0;
        int           guard = 0;
        logic         xfer = 1'b0;
        logic [511:0] snap = '0;
        logic         snap_new = 1'b0;
        while (got < nblk && guard < 4000) begin
            @(posedge clk); #1;
            guard++;
            if (xfer) begin
                blk_ready = 1'b0;
                xfer = 1'b0;
                chk("valid_drop", blk_valid, 0);
            end else if (blk_valid) begin
                chk("in_ready_blocked", in_ready, 0);
                if (waited == 0) begin
                    snap = blk_data;
                    snap_new = blk_new;
                    seen_cyc.push_back(cyc);
                end else begin
                    chk("stall_data", blk_data, snap);
                    chk("stall_new", blk_new, snap_new);
                end
                if (waited >= stall) begin
                    got_q.push_back(blk_data);
                    got_new_q.push_back(blk_new);
                    rdy_cyc.push_back(cyc);
                    blk_ready = 1'b1;
                    xfer = 1'b1;
                    got++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end
        end
        if (xfer) begin
            @(posedge clk); #1;
            blk_ready = 1'b0;
            chk("valid_drop", blk_valid, 0);
        end
        chk("blk_count", got, nblk);
    endtask

    task automatic run_msg(input string name, input int stall, input int gap);
        int n;
        model();
        got_q.delete();
        got_new_q.delete();
        seen_cyc.delete();
        rdy_cyc.delete();
        fork
            drive(gap, 1'b1);
            collect(exp_q.size(), stall);
        join
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            chk({name, "_data"}, got_q[k], exp_q[k]);
            chk({name, "_new"}, got_new_q[k], (k == 0));
        end
    endtask

    vec_t vecs[6];
    logic [511:0] abc_blk;
    logic [511:0] blk_tmp;

    initial begin
        abc_blk = {32'h61626380, 416'h0, 64'h18};
        vecs[0] = '{len: 55,  fill: 8'h41, stall: 0, exp_blk: 1, exp_len: 64'h1B8, pad_blk: 0, pad_byte: 55};
        vecs[1] = '{len: 56,  fill: 8'h41, stall: 0, exp_blk: 2, exp_len: 64'h1C0, pad_blk: 0, pad_byte: 56};
        vecs[2] = '{len: 64,  fill: 8'h00, stall: 0, exp_blk: 2, exp_len: 64'h200, pad_blk: 1, pad_byte: 0};
        vecs[3] = '{len: 130, fill: 8'h5A, stall: 5, exp_blk: 3, exp_len: 64'h410, pad_blk: 2, pad_byte: 2};
        vecs[4] = '{len: 1,   fill: 8'hFF, stall: 2, exp_blk: 1, exp_len: 64'h008, pad_blk: 0, pad_byte: 1};
        vecs[5] = '{len: 63,  fill: 8'h11, stall: 1, exp_blk: 2, exp_len: 64'h1F8, pad_blk: 0, pad_byte: 63};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_blk_new", blk_new, 0);
        chk("rst_blk_data", blk_data, 0);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_rise", in_ready, 1);

        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("abc", 0, 0);
        if (got_q.size() > 0) begin
            chk("abc_const", got_q[0], abc_blk);
            chk("abc_latency", seen_cyc[0] - last_pres, 2);
        end

        for (int v = 0; v < 6; v++) begin
            msg_q.delete();
            for (int i = 0; i < vecs[v].len; i++) msg_q.push_back(vecs[v].fill);
            run_msg($sformatf("vec%0d", v), vecs[v].stall, 0);
            chk("vec_blocks", got_q.size(), vecs[v].exp_blk);
            if (got_q.size() == vecs[v].exp_blk) begin
                blk_tmp = got_q[vecs[v].exp_blk - 1];
                chk("vec_len_field", blk_tmp[63:0], vecs[v].exp_len);
                blk_tmp = got_q[vecs[v].pad_blk];
                chk("vec_pad_byte", blk_tmp[511-8*vecs[v].pad_byte -: 8], 8'h80);
                if (vecs[v].len > 64)
                    chk("full_blk_latency", seen_cyc[0] - pres63, 1);
                if (vecs[v].len % 64 == 0 || vecs[v].len % 64 >= 56)
                    chk("extra_latency", seen_cyc[vecs[v].exp_blk - 1] - rdy_cyc[vecs[v].exp_blk - 2], 2);
            end
        end

        // Partial message discarded by a one-cycle reset.
        msg_q.delete();
        for (int i = 0; i < 20; i++) msg_q.push_back(8'(i + 1));
        drive(0, 1'b0);
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_blk_data", blk_data, 0);
        @(posedge clk); #1;
        msg_q = '{8'h61, 8'h62, 8'h63};
        run_msg("abc_after_rst", 0, 0);
        if (got_q.size() > 0) begin
            chk("abc2_const", got_q[0], abc_blk);
            chk("abc2_new", got_new_q[0], 1);
            chk("abc2_latency", seen_cyc[0] - last_pres, 2);
        end

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 150);
            msg_q.delete();
            for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
            run_msg($sformatf("rand%0d_len%0d", r, n), $urandom_range(0, 3), 30);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
